vcve2_vrf_seq: RTL

- Sequencer directly upstream of the vector AGU.
- Accepts one vector instruction from the pipeline and latches its rs1/rs2/rd indices and word count.
- Drives the AGU's load/get/incr controls and runs OBI-style memory transactions on the VRF memory: read rs1 word, read rs2 word, hand the operands to the vector lane, then write the result word to rd.
- Repeats per 32-bit word until vl words are done, then pulses done_o.

---
 rtl/vcve2_vrf_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/vcve2_vrf_seq.sv
`default_nettype none
// ============================================================================
// Module   : vcve2_vrf_seq
// Purpose  : Per-word vector sequencer: AGU control, VRF reads/writes, lane handoff.
// Revision : 1.0
// ============================================================================
module vcve2_vrf_seq #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned VlenWords = 4,
    parameter int unsigned VlWidth   = $clog2(VlenWords) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    output logic                   ready_o,
    input  logic [4:0]             rs1_i,
    input  logic [4:0]             rs2_i,
    input  logic [4:0]             rd_i,
    input  logic                   use_rs2_i,
    input  logic [VlWidth-1:0]     vl_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4:0]             agu_rs1_o,
    output logic [4:0]             agu_rs2_o,
    output logic [4:0]             agu_rd_o,
    output logic                   agu_load_o,
    output logic                   agu_get_rs1_o,
    output logic                   agu_get_rs2_o,
    output logic                   agu_get_rd_o,
    output logic                   agu_incr_o,
    input  logic [AddrWidth-1:0]   agu_addr_i,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    output logic                   op_valid_o,
    output logic [DataWidth-1:0]   op_a_o,
    output logic [DataWidth-1:0]   op_b_o,
    input  logic                   res_valid_i,
    input  logic [DataWidth-1:0]   res_i
);

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_load     = 4'd1;
    localparam logic [3:0] c_st_rs1_req  = 4'd2;
    localparam logic [3:0] c_st_rs1_wait = 4'd3;
    localparam logic [3:0] c_st_rs2_req  = 4'd4;
    localparam logic [3:0] c_st_rs2_wait = 4'd5;
    localparam logic [3:0] c_st_exec     = 4'd6;
    localparam logic [3:0] c_st_wr_req   = 4'd7;
    localparam logic [3:0] c_st_wr_wait  = 4'd8;
    localparam logic [3:0] c_st_done     = 4'd9;

    localparam logic [VlWidth-1:0] c_vl_max = VlWidth'(VlenWords);

    logic [3:0]           state_q,   state_d;
    logic [4:0]           rs1_q,     rs1_d;
    logic [4:0]           rs2_q,     rs2_d;
    logic [4:0]           rd_q,      rd_d;
    logic                 use_rs2_q, use_rs2_d;
    logic [VlWidth-1:0]   vl_q,      vl_d;
    logic [VlWidth-1:0]   cnt_q,     cnt_d;
    logic [DataWidth-1:0] op_a_q,    op_a_d;
    logic [DataWidth-1:0] op_b_q,    op_b_d;
    logic [DataWidth-1:0] wdata_q,   wdata_d;

    logic w_last_word;
    assign w_last_word = (cnt_q == (vl_q - VlWidth'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            use_rs2_q <= 1'b0;
            vl_q      <= '0;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            use_rs2_q <= use_rs2_d;
            vl_q      <= vl_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            wdata_q   <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:     if (start_i) state_d = (vl_i == '0) ? c_st_done : c_st_load;
            c_st_load:     state_d = c_st_rs1_req;
            c_st_rs1_req:  if (mem_gnt_i) state_d = c_st_rs1_wait;
            c_st_rs1_wait: if (mem_rvalid_i) state_d = use_rs2_q ? c_st_rs2_req : c_st_exec;
            c_st_rs2_req:  if (mem_gnt_i) state_d = c_st_rs2_wait;
            c_st_rs2_wait: if (mem_rvalid_i) state_d = c_st_exec;
            c_st_exec:     if (res_valid_i) state_d = c_st_wr_req;
            c_st_wr_req:   if (mem_gnt_i) state_d = c_st_wr_wait;
            c_st_wr_wait:  if (mem_rvalid_i) state_d = w_last_word ? c_st_done : c_st_rs1_req;
            c_st_done:     state_d = c_st_idle;
            default:       state_d = c_st_idle;
        endcase
    end

    // Datapath register updates
    always_comb begin
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        use_rs2_d = use_rs2_q;
        vl_d      = vl_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        wdata_d   = wdata_q;
        case (state_q)
            c_st_idle: begin
                if (start_i) begin
                    rs1_d     = rs1_i;
                    rs2_d     = rs2_i;
                    rd_d      = rd_i;
                    use_rs2_d = use_rs2_i;
                    // Out-of-range lengths saturate at the register size
                    vl_d      = (vl_i > c_vl_max) ? c_vl_max : vl_i;
                    cnt_d     = '0;
                end
            end
            c_st_rs1_wait: begin
                if (mem_rvalid_i) begin
                    op_a_d = mem_rdata_i;
                    if (!use_rs2_q) begin
                        op_b_d = '0;
                    end
                end
            end
            c_st_rs2_wait: begin
                if (mem_rvalid_i) begin
                    op_b_d = mem_rdata_i;
                end
            end
            c_st_exec: begin
                if (res_valid_i) begin
                    wdata_d = res_i;
                end
            end
            c_st_wr_wait: begin
                if (mem_rvalid_i && !w_last_word) begin
                    cnt_d = cnt_q + VlWidth'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        ready_o       = 1'b0;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        agu_load_o    = 1'b0;
        agu_get_rs1_o = 1'b0;
        agu_get_rs2_o = 1'b0;
        agu_get_rd_o  = 1'b0;
        agu_incr_o    = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_wdata_o   = '0;
        op_valid_o    = 1'b0;
        case (state_q)
            c_st_idle: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
            end
            c_st_load:    agu_load_o = 1'b1;
            c_st_rs1_req: begin
                mem_req_o     = 1'b1;
                agu_get_rs1_o = 1'b1;
                agu_incr_o    = mem_gnt_i;
            end
            c_st_rs2_req: begin
                mem_req_o     = 1'b1;
                agu_get_rs2_o = 1'b1;
                agu_incr_o    = mem_gnt_i;
            end
            c_st_exec:    op_valid_o = 1'b1;
            c_st_wr_req: begin
                mem_req_o    = 1'b1;
                mem_we_o     = 1'b1;
                mem_wdata_o  = wdata_q;
                agu_get_rd_o = 1'b1;
                agu_incr_o   = mem_gnt_i;
            end
            c_st_done:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr_o = mem_req_o ? agu_addr_i : '0;
    assign mem_be_o   = mem_req_o ? {(DataWidth/8){1'b1}} : '0;
    assign agu_rs1_o  = rs1_q;
    assign agu_rs2_o  = rs2_q;
    assign agu_rd_o   = rd_q;
    assign op_a_o     = op_a_q;
    assign op_b_o     = op_b_q;

endmodule
`default_nettype wire
